// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier controller.
// Imported by the interface, the arbiter and the controller top.
package mult_share_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_ID_W     = $clog2(DEF_NUM_REQ);
  localparam int DEF_BUSY_TMO = 4;
  localparam int OPND_W       = 32;
  localparam int PROD_W       = 64;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester and multiplier bus of the shared-multiplier controller.
// master = controller side, slave = requesters plus the multiplier.
interface mult_share_ctrl_if
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*OPND_W-1:0] req_a;
  logic [NUM_REQ*OPND_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [PROD_W-1:0]         resp_product;
  logic                      mul_start;
  logic [OPND_W-1:0]         mul_a;
  logic [OPND_W-1:0]         mul_b;
  logic                      mul_busy;
  logic [PROD_W-1:0]         mul_product;
  logic                      arb_busy;

  modport master (
    input  req_valid, req_a, req_b, mul_busy, mul_product,
    output req_ready, resp_valid, resp_id, resp_product,
           mul_start, mul_a, mul_b, arb_busy
  );

  modport slave (
    output req_valid, req_a, req_b, mul_busy, mul_product,
    input  req_ready, resp_valid, resp_id, resp_product,
           mul_start, mul_a, mul_b, arb_busy
  );

endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one iterative 32x32 multiplier among NUM_REQ requesters: round-robin
// accept, start/busy sequencing with a busy-rise timeout, one-cycle response.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic              clk,
  input  logic              reset,
  mult_share_ctrl_if.master bus
);

  localparam int              CNT_W    = cnt_width(BUSY_TMO);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic [OPND_W-1:0]   mul_a_q;
  logic [OPND_W-1:0]   mul_b_q;
  logic                mul_start_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [ID_W-1:0]     resp_id_q;
  logic [PROD_W-1:0]   resp_product_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_req;
  logic                accept;
  logic                enter_done;
  logic [OPND_W-1:0]   sel_a;
  logic [OPND_W-1:0]   sel_b;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_req)
  );

  // Reset masks the combinational accept so no grant is shown while resetting.
  assign accept = (state_q == IDLE) && any_req && !reset;

  assign rr_ptr_d = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;

  // A multiplier that never raises busy is treated as a zero-length operation.
  assign enter_done = !bus.mul_busy &&
                      (((state_q == WAIT_BUSY) && (tmo_cnt_q == TMO_LAST)) ||
                       (state_q == RUN));

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[OPND_W*i +: OPND_W];
        sel_b = bus.req_b[OPND_W*i +: OPND_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      cur_id_q       <= '0;
      tmo_cnt_q      <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_start_q    <= 1'b0;
      resp_valid_q   <= '0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
    end else begin
      mul_start_q  <= 1'b0;
      resp_valid_q <= '0;

      if (enter_done) begin
        resp_valid_q   <= onehot(cur_id_q);
        resp_id_q      <= cur_id_q;
        resp_product_q <= bus.mul_product;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            mul_a_q     <= sel_a;
            mul_b_q     <= sel_b;
            cur_id_q    <= grant_idx;
            mul_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.mul_busy) begin
            state_q <= RUN;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!bus.mul_busy) state_q <= DONE;
        end
        DONE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = accept ? grant : '0;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_product = resp_product_q;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.arb_busy     = (state_q != IDLE);

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Controller/arbiter that shares one mult32x32_fast instance between NUM_REQ requesters.
- Selects a requester round-robin and registers its operands.
- Sequences the multiplier's start/busy handshake and returns the 64-bit product to the selected requester with a one-cycle response pulse.
- Sits between client blocks and the multiplier.
- Holds mul_a/mul_b stable for the whole iterative operation.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index
BUSY_TMO, 4, cycles to wait for mul_busy to rise after mul_start before treating the operation as complete

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held high until req_ready
req_a  in  NUM_REQ*32  packed operand a, requester i at [32i+31:32i]
req_b  in  NUM_REQ*32  packed operand b
req_ready  out  NUM_REQ  one-hot accept pulse (combinational, IDLE only)
resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
resp_id  out  ID_W  index of the requester served (valid with resp_valid)
resp_product  out  64  registered product (valid with resp_valid)
mul_start  out  1  start pulse to the multiplier
mul_a  out  32  operand a to the multiplier; registered
mul_b  out  32  operand b to the multiplier; registered
mul_busy  in  1  multiplier busy
mul_product  in  64  multiplier product
arb_busy  out  1  high whenever state != IDLE

Behaviour:
Reset (sync, active-high):
- state=IDLE, rr_ptr=0.
- req_ready=0, resp_valid=0, resp_id=0, resp_product=0, mul_start=0, mul_a=0, mul_b=0, arb_busy=0.
- Reset mid-operation aborts immediately; no resp_valid is issued. The multiplier shares the same reset.

States: IDLE -> START -> WAIT_BUSY -> RUN -> DONE -> IDLE.
- IDLE:
  - Winner g = first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ.
  - If any request: req_ready[g]=1 this cycle; at the edge capture mul_a/mul_b <= req_a/req_b[g] and cur_id <= g; go to START.
  - Otherwise stay in IDLE.
- START: mul_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - mul_busy=1 -> RUN.
  - Else increment the counter; when the counter reaches BUSY_TMO-1 -> DONE (zero-length operation path).
- RUN: stay while mul_busy=1; on mul_busy=0 -> DONE.
- DONE:
  - resp_valid[cur_id]=1, resp_id=cur_id, resp_product <= mul_product (registered; visible during the DONE cycle).
  - rr_ptr <= (cur_id+1) mod NUM_REQ; go to IDLE.

Handshake and timing:
- A requester deasserts or changes req_valid only after req_ready. Requests arriving in any non-IDLE state wait; req_ready stays 0 outside IDLE.
- mul_a/mul_b change only on the IDLE accept edge; they are constant from START through DONE.
- Back-to-back: the cycle after DONE is IDLE, which can accept immediately.
- Minimum request-to-response latency = multiplier busy cycles + 4.
- Simultaneous requests: exactly one is granted per IDLE cycle, round-robin. No requester starves: worst-case wait is NUM_REQ-1 operations.
- resp_product holds its value between responses. resp_id holds its last value.

Decomposition:
- Package mult_share_pkg: state enum (IDLE, START, WAIT_BUSY, RUN, DONE), ID_W-derived constants, default BUSY_TMO.
- Sub-module rr_arbiter: NUM_REQ request vector plus rr_ptr -> one-hot grant and encoded index. Purely combinational; rr_ptr register lives in the parent.

Test Plan:
- Single request: req0 a=32'h0000_0003, b=32'h0000_0005 -> req_ready[0] in the first IDLE cycle, one mul_start pulse, resp_valid[0] with resp_product=64'd15, resp_id=0.
- All 4 valid at once with a=i+1, b=32'h1000_0000 -> service order 0,1,2,3. Products i+1 × 2^28 on the matching resp_id. No overlapping mul_start.
- Fairness: req1 and req3 held high continuously with rr_ptr=0 -> grants alternate 1,3,1,3 over 4 operations.
- Large operands: a=b=32'hFFFF_FFFF -> resp_product=64'hFFFF_FFFE_0000_0001. mul_a/mul_b stay constant from START to DONE (assertion).
- Stubbed multiplier that never raises busy -> DONE after BUSY_TMO cycles in WAIT_BUSY, resp_valid pulses with the current mul_product, controller returns to IDLE.
- Reset asserted while in RUN -> next cycle all outputs at reset values and no resp_valid. A pending request is re-accepted after reset deasserts, starting from rr_ptr=0.
